tensor_slice_drain: RTL and testbench
=====================================

TENSOR_SLICE_DRAIN -- requirements
Module: tensor_slice_drain

Interface
REQ-001 SHALL have parameter ROWS, default 8: rows of C produced per tile pass; row index wraps at ROWS.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  begins a new accumulation job; sampled only in IDLE.
REQ-006 SHALL have port num_ktiles  input  8  K-tiles to accumulate per job; latched at start; 0 treated as 1.
REQ-007 SHALL have port c_data_in  input  128  one row of C from the tensor slice: 8 lanes, signed int16, lane i at [16i+15:16i].
REQ-008 SHALL have port c_data_valid  input  1  c_data_in valid this cycle; driven by the slice c_data_available.
REQ-009 SHALL have port out_data  output  256  accumulated row: 8 lanes, signed int32, lane i at [32i+31:32i].
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port busy  output  1  high in ACCUM.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the last row of the job is pushed.
REQ-014 SHALL have port overflow  output  1  sticky; set on a push to a full FIFO; cleared only by reset.
REQ-015 SHALL have port stray  output  1  sticky; set on c_data_valid in IDLE; cleared by start or reset.
REQ-016 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL implement FSM with states IDLE and ACCUM; IDLE -> ACCUM on start; ACCUM -> IDLE in the cycle after the final push.
REQ-018 SHALL, on start, latch max(num_ktiles,1), zero row_idx and ktile_idx, zero all ROWS x 8 int32 accumulators, and clear stray.
REQ-019 SHALL, in ACCUM on c_data_valid, sign-extend each lane to 32 bits and add it to ACC[row_idx][lane]; arithmetic is wrap-free, since 255 x 32767 fits int32.
REQ-020 SHALL advance row_idx by 1 per accepted row, wrap it to 0 after ROWS-1, and increment ktile_idx on that wrap.
REQ-021 SHALL, when ktile_idx equals the latched count minus 1, push ACC[row_idx] plus the incoming row to the FIFO in the same cycle instead of writing back, and then zero ACC[row_idx].
REQ-022 SHALL make a pushed row visible on out_data/out_valid one cycle after the accepting c_data_valid.
REQ-023 SHALL assert done for exactly one cycle, in the cycle after the push of row ROWS-1 of the final tile.
REQ-024 SHALL drop the pushed row and set overflow when the FIFO is full, unless a pop occurs in the same cycle; simultaneous push and pop on a full FIFO SHALL succeed, with count unchanged.
REQ-025 SHALL leave count unchanged on simultaneous push and pop on an empty FIFO, and SHALL NOT output the pushed row in that cycle (no fall-through).
REQ-026 SHALL make FIFO pointers wrap modulo FIFO_DEPTH and present out_data from the head entry; out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 SHALL ignore start while in ACCUM.
REQ-028 SHALL ignore c_data_valid in IDLE, apart from setting stray.
REQ-029 SHALL continue FIFO draining in IDLE.

Reset
REQ-030 SHALL, while reset is low at a clock edge, force FSM to IDLE and set row_idx=0, ktile_idx=0, FIFO empty, out_valid=0, fifo_count=0, busy=0, done=0, overflow=0, stray=0, out_data=0.
REQ-031 SHALL, on reset asserted mid-job, abandon the job and discard FIFO contents; accumulators SHALL need no reset because start zeroes them.

Verification
REQ-032 SHALL be verified by: num_ktiles=1, eight rows with lane value r+1 (r=row), out_ready=1 -> eight outputs, all lanes of output r = r+1, done one cycle after the eighth push.
REQ-033 SHALL be verified by: num_ktiles=3, every lane -32768 in all 24 rows -> eight outputs, each lane -98304 (0xFFFE8000).
REQ-034 SHALL be verified by: num_ktiles=1, out_ready=0, FIFO_DEPTH=4, eight rows -> fifo_count saturates at 4, overflow=1, first four rows retained in order.
REQ-035 SHALL be verified by: full FIFO with out_ready=1 during a push -> no overflow, count stays at 4, output order preserved.
REQ-036 SHALL be verified by: c_data_valid pulsed in IDLE -> stray=1, no push; a following start clears stray.
REQ-037 SHALL be verified by: reset low after 5 rows of a num_ktiles=2 job -> all outputs at reset values; a new job with num_ktiles=1 then produces correct sums with no residue.

Source files
------------

// File: rtl/tensor_slice_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tensor_slice_drain
//  Brief    : Accumulates C rows from a tensor slice over K-tiles and drains
//             the finished int32 rows through a small output FIFO.
//  Revision : 1.0
// ============================================================================
module tensor_slice_drain #(
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [7:0]                      num_ktiles,
  input  logic [127:0]                    c_data_in,
  input  logic                            c_data_valid,
  output logic [255:0]                    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic                            stray,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int LANES = 8;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t              r_state;
  logic [RW-1:0]       r_row_idx;
  logic [7:0]          r_ktile_idx;
  logic [7:0]          r_ktiles;
  logic signed [31:0]  r_acc [ROWS][LANES];
  logic [255:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_done;
  logic                r_overflow;
  logic                r_stray;

  logic                w_accept;
  logic                w_last_ktile;
  logic                w_last_row;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_wr_en;
  logic [255:0]        w_sum;

  assign w_accept     = (r_state == ACCUM) && c_data_valid;
  assign w_last_ktile = (r_ktile_idx == (r_ktiles - 8'd1));
  assign w_last_row   = (r_row_idx == RW'(ROWS - 1));
  assign w_push       = w_accept && w_last_ktile;
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_pop        = (r_count != '0) && out_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign w_wr_en      = w_push && (!w_full || w_pop);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_sum[32*l +: 32] = r_acc[r_row_idx][l] +
                               {{16{c_data_in[16*l+15]}}, c_data_in[16*l +: 16]};
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int l = 0; l < LANES; l++) begin
          r_acc[r][l] <= 32'sd0;
        end
      end
    end else if (w_accept) begin
      for (int l = 0; l < LANES; l++) begin
        r_acc[r_row_idx][l] <= w_last_ktile ? 32'sd0 : $signed(w_sum[32*l +: 32]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_row_idx   <= '0;
      r_ktile_idx <= '0;
      r_ktiles    <= 8'd1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= ACCUM;
            r_ktiles    <= (num_ktiles == 8'd0) ? 8'd1 : num_ktiles;
            r_row_idx   <= '0;
            r_ktile_idx <= '0;
            r_stray     <= 1'b0;
          end else if (c_data_valid) begin
            r_stray <= 1'b1;
          end
        end
        ACCUM: begin
          if (c_data_valid) begin
            if (w_last_row) begin
              r_row_idx   <= '0;
              r_ktile_idx <= r_ktile_idx + 8'd1;
            end else begin
              r_row_idx <= r_row_idx + RW'(1);
            end
            if (w_last_ktile && w_last_row) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - CW'(1);
      if (w_push && !w_wr_en)     r_overflow <= 1'b1;
    end
  end

  assign out_data   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign out_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign busy       = (r_state == ACCUM);
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign stray      = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_tensor_slice_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tensor_slice_drain
//  Brief    : Directed and randomized bench for tensor_slice_drain with a
//             cycle-level reference model built from row sums and a queue.
//  Revision : 1.0
// ============================================================================
module tb_tensor_slice_drain;

  localparam int ROWS  = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   num_ktiles = 8'd0;
  logic [127:0] c_data_in = '0;
  logic         c_data_valid = 1'b0;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         stray;
  logic [2:0]   fifo_count;

  tensor_slice_drain #(.ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_ktiles(num_ktiles),
    .c_data_in(c_data_in), .c_data_valid(c_data_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow), .stray(stray),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: per-row running sums, expected FIFO contents, flags.
  int           m_acc [ROWS][8];
  logic [255:0] q [$];
  bit           m_busy, m_done, m_ovf, m_stray;
  int           m_row, m_kt, m_nk;

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit pop, push, fin;
    int pre;
    logic [255:0] row;
    pop  = (q.size() != 0) && out_ready;
    push = 1'b0;
    fin  = 1'b0;
    row  = '0;
    m_done = 1'b0;
    if (!reset) begin
      q.delete();
      m_busy = 0; m_row = 0; m_kt = 0; m_ovf = 0; m_stray = 0;
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_row = 0; m_kt = 0; m_stray = 0;
          m_nk = (num_ktiles == 0) ? 1 : int'(num_ktiles);
          foreach (m_acc[r, l]) m_acc[r][l] = 0;
        end else if (c_data_valid) begin
          m_stray = 1;
        end
      end else if (c_data_valid) begin
        for (int l = 0; l < 8; l++)
          m_acc[m_row][l] += int'(signed'(c_data_in[16*l +: 16]));
        if (m_kt == m_nk - 1) begin
          for (int l = 0; l < 8; l++) begin
            row[32*l +: 32] = m_acc[m_row][l];
            m_acc[m_row][l] = 0;
          end
          push = 1'b1;
        end
        m_row++;
        if (m_row == ROWS) begin
          m_row = 0;
          if (m_kt == m_nk - 1) fin = 1'b1;
          m_kt++;
        end
      end
      pre = q.size();
      if (pop) void'(q.pop_front());
      if (push) begin
        if (pre < DEPTH || pop) q.push_back(row);
        else m_ovf = 1;
      end
      if (fin) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid",  256'(out_valid),  256'(q.size() != 0));
    check("fifo_count", 256'(fifo_count), 256'(q.size()));
    check("out_data",   out_data, (q.size() != 0) ? q[0] : 256'd0);
    check("busy",       256'(busy),     256'(m_busy));
    check("done",       256'(done),     256'(m_done));
    check("overflow",   256'(overflow), 256'(m_ovf));
    check("stray",      256'(stray),    256'(m_stray));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_job(int nk);
    start = 1'b1;
    num_ktiles = 8'(nk);
    step();
    start = 1'b0;
  endtask

  task automatic rows(int n, bit rnd, logic [127:0] val);
    for (int i = 0; i < n; i++) begin
      c_data_valid = 1'b1;
      c_data_in = rnd ? rnd128() : val;
      step();
    end
    c_data_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  logic [255:0] c_neg = {8{32'hFFFE8000}};
  logic [15:0]  v16;

  initial begin
    foreach (m_acc[r, l]) m_acc[r][l] = 0;
    m_busy = 0; m_done = 0; m_ovf = 0; m_stray = 0; m_row = 0; m_kt = 0; m_nk = 1;

    // Reset state, then one K-tile with lane value r+1 per row.
    do_reset();
    out_ready = 1'b1;
    start_job(1);
    for (int r = 0; r < ROWS; r++) begin
      v16 = 16'(r + 1);
      rows(1, 0, {8{v16}});
    end
    idle(3);

    // Three K-tiles of -32768: hold the output to inspect a full row.
    out_ready = 1'b0;
    start_job(3);
    rows(20, 0, {8{16'h8000}});
    check("neg_count", 256'(fifo_count), 256'd4);
    check("neg_row0",  out_data, c_neg);
    out_ready = 1'b1;
    rows(4, 0, {8{16'h8000}});
    idle(6);

    // Blocked consumer: FIFO saturates, overflow sticks, first rows kept.
    out_ready = 1'b0;
    start_job(1);
    rows(8, 1, '0);
    check("sat_count", 256'(fifo_count), 256'd4);
    check("sat_ovf",   256'(overflow),   256'd1);
    out_ready = 1'b1;
    idle(6);

    // Full FIFO with simultaneous pop on every push: no overflow.
    do_reset();
    out_ready = 1'b0;
    start_job(1);
    rows(4, 1, '0);
    out_ready = 1'b1;
    rows(4, 1, '0);
    check("pp_ovf",   256'(overflow),   256'd0);
    check("pp_count", 256'(fifo_count), 256'd4);
    idle(6);

    // Stray data in IDLE, cleared by the next start.
    rows(1, 1, '0);
    check("stray_set",  256'(stray),      256'd1);
    check("stray_nop",  256'(fifo_count), 256'd0);
    start_job(1);
    check("stray_clr",  256'(stray),      256'd0);
    rows(8, 1, '0);
    idle(6);

    // Reset mid-job, then a clean job with no residue.
    start_job(2);
    rows(5, 1, '0);
    reset = 1'b0;
    idle(1);
    check("mid_rst_busy", 256'(busy),     256'd0);
    check("mid_rst_data", out_data,       256'd0);
    reset = 1'b1;
    start_job(1);
    rows(8, 1, '0);
    idle(6);

    // Randomized jobs: gaps in valid, random backpressure, ignored starts.
    for (int j = 0; j < 8; j++) begin
      int budget;
      start_job(int'($urandom_range(0, 3)));
      budget = 300;
      while (m_busy && budget > 0) begin
        c_data_valid = ($urandom_range(0, 3) != 0);
        c_data_in    = rnd128();
        out_ready    = ($urandom_range(0, 2) != 0);
        start        = ($urandom_range(0, 7) == 0);
        num_ktiles   = 8'($urandom_range(0, 255));
        step();
        budget--;
      end
      start = 1'b0;
      c_data_valid = 1'b0;
      check("rand_job_end", 256'(busy), 256'd0);
      out_ready = 1'b1;
      idle(5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
